pwm_fade_ctrl: RTL
==================

Name: pwm_fade_ctrl

Overview:
- Sequencer for the 8-bit PWM duty input: accepts fade commands (target duty, step size, rate) over a valid/ready handshake.
- Ramps its duty output toward the target, changing it only on PWM period boundaries so the PWM never sees a mid-period duty change.
- Sits between command logic (LED patterns, host register) and the PWM generator in top; duty output drives the PWM duty input directly.

Parameters:
- WIDTH, 8, duty width; matches the PWM counter width.
- RATE_W, 16, width of the rate (PWM-periods-per-step) field.
- RESET_DUTY, 0, duty value after reset.

Ports:
- clk  input  1  system clock, 12 MHz
- rst  input  1  synchronous reset, active-high
- pwm_wrap  input  1  one-cycle pulse when the PWM counter wraps from 2^WIDTH-1 to 0
- cmd_valid  input  1  command present
- cmd_ready  output  1  block can accept a command
- cmd_target  input  WIDTH  destination duty
- cmd_step  input  WIDTH  duty change per step; 0 treated as 1
- cmd_rate  input  RATE_W  extra PWM periods between steps; 0 = step on every wrap
- duty  output  WIDTH  duty value to the PWM generator
- busy  output  1  ramp in progress
- done  output  1  one-cycle pulse when duty reaches target

Behaviour:
- Single clock domain. All state updates on posedge clk. rst is synchronous, active-high, and has priority over everything.
- Reset values: duty=RESET_DUTY, state=IDLE, cmd_ready=1, busy=0, done=0, rate counter=0.
- States: IDLE and RAMP.
- IDLE:
  - cmd_ready=1, busy=0.
  - Accept when cmd_valid && cmd_ready; latch target, step (0→1) and rate; load rate_cnt=cmd_rate.
  - If cmd_target==duty: stay IDLE, done=1 on the next cycle, duty unchanged.
  - Otherwise: state=RAMP on the next cycle.
- RAMP:
  - cmd_ready=0, busy=1. cmd_valid is ignored, not queued.
  - On a cycle with pwm_wrap=1:
    - If rate_cnt==0: step duty toward target and reload rate_cnt=rate.
    - Else: rate_cnt decrements.
  - Cycles without pwm_wrap change nothing.
  - Net effect: the first step happens on wrap number rate+1 after accept; further steps every rate+1 wraps.
- Step arithmetic (WIDTH+1-bit intermediate, no wrap-around):
  - Up: duty=min(duty+step, target).
  - Down: duty=max(duty-step, target); the difference is compared before subtracting, so no underflow.
  - The clamp guarantees no overshoot and no modular wrap (e.g. 250+8 toward 255 gives 255, never 2).
- Completion: on the wrap cycle where duty is written equal to target, the next cycle has state=IDLE, done=1 (exactly one cycle), busy=0, cmd_ready=1.
  - A command may be accepted in that same cycle.
- Latency: duty changes register one cycle after the triggering pwm_wrap edge, i.e. the new value is visible at the start of the new PWM period. The PWM module samples duty continuously; updates occur only in wrap cycles.
- pwm_wrap held high for several cycles: each high cycle counts as a wrap. The source must pulse.
- Reset mid-ramp: duty returns to RESET_DUTY, the command is discarded, and no done pulse is issued.
- Estimated size: ~150 lines RTL.

Test Plan:
1. Reset: assert rst 3 cycles with cmd_valid=1 → duty=0, busy=0, cmd_ready=1, done=0, no command accepted.
2. Ramp up: duty=0; cmd target=4, step=1, rate=0; pulse pwm_wrap every 256 cycles → duty 1,2,3,4 after wraps 1–4; done high exactly one cycle after wrap 4; busy low from then on.
3. Rate and clamp down: start at duty=10; cmd target=3, step=4, rate=2 → duty=6 after wrap 3, duty=3 (clamped, not 2) after wrap 6, then done; duty unchanged on wraps 1, 2, 4, 5.
4. Saturation: duty=250; cmd target=255, step=8, rate=0 → duty=255 after the first wrap, done, never wraps to a low value. cmd_step=0 with target 252 from 250 → steps of 1.
5. Backpressure and no-op:
   - During RAMP, hold cmd_valid with target=0 → cmd_ready=0, ramp continues to the original target.
   - Issue target==current duty → done pulse one cycle after accept, duty unchanged, busy never high.
6. Reset mid-ramp: ramp 0→200 step 1; assert rst after wrap 50 (duty=50) → duty=0 next cycle, IDLE, no done pulse; a new command accepted immediately after rst deasserts.

Source files
------------

// File: rtl/pwm_fade_ctrl.sv
// Fade sequencer for the PWM duty input: ramps duty toward a commanded target,
// updating only on PWM wrap cycles so the generator never sees a mid-period change.
module pwm_fade_ctrl #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned RATE_W     = 16,
  parameter int unsigned RESET_DUTY = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pwm_wrap,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [WIDTH-1:0]  cmd_target,
  input  logic [WIDTH-1:0]  cmd_step,
  input  logic [RATE_W-1:0] cmd_rate,
  output logic [WIDTH-1:0]  duty,
  output logic              busy,
  output logic              done
);

  typedef enum logic {IDLE, RAMP} state_t;

  state_t              state, state_n;
  logic [WIDTH-1:0]    target, target_n;
  logic [WIDTH-1:0]    step, step_n;
  logic [RATE_W-1:0]   rate, rate_n;
  logic [RATE_W-1:0]   rate_cnt, rate_cnt_n;
  logic [WIDTH-1:0]    duty_n;
  logic                done_n;
  logic                cmd_ready_n;
  logic                busy_n;

  logic [WIDTH:0]      sum;
  logic [WIDTH-1:0]    gap;
  logic [WIDTH-1:0]    stepped;

  // One clamped step toward target; the extra sum bit and the pre-subtract
  // compare keep the result from wrapping around.
  always_comb begin
    sum     = {1'b0, duty} + {1'b0, step};
    gap     = duty - target;
    stepped = duty;
    if (target > duty) begin
      stepped = (sum >= {1'b0, target}) ? target : sum[WIDTH-1:0];
    end else begin
      stepped = (gap <= step) ? target : (duty - step);
    end
  end

  always_comb begin
    state_n     = state;
    target_n    = target;
    step_n      = step;
    rate_n      = rate;
    rate_cnt_n  = rate_cnt;
    duty_n      = duty;
    done_n      = 1'b0;
    unique case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          target_n   = cmd_target;
          step_n     = (cmd_step == '0) ? WIDTH'(1) : cmd_step;
          rate_n     = cmd_rate;
          rate_cnt_n = cmd_rate;
          if (cmd_target == duty) begin
            done_n = 1'b1;
          end else begin
            state_n = RAMP;
          end
        end
      end
      RAMP: begin
        if (pwm_wrap) begin
          if (rate_cnt == '0) begin
            duty_n     = stepped;
            rate_cnt_n = rate;
            if (stepped == target) begin
              state_n = IDLE;
              done_n  = 1'b1;
            end
          end else begin
            rate_cnt_n = rate_cnt - RATE_W'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
    cmd_ready_n = (state_n == IDLE);
    busy_n      = (state_n == RAMP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      target    <= '0;
      step      <= WIDTH'(1);
      rate      <= '0;
      rate_cnt  <= '0;
      duty      <= WIDTH'(RESET_DUTY);
      done      <= 1'b0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      target    <= target_n;
      step      <= step_n;
      rate      <= rate_n;
      rate_cnt  <= rate_cnt_n;
      duty      <= duty_n;
      done      <= done_n;
      cmd_ready <= cmd_ready_n;
      busy      <= busy_n;
    end
  end

endmodule
